// File: rtl/modadd_arbiter_if.sv
// Bundle between the EC point-arithmetic requesters, the modadd arbiter and the
// single shared modular add/sub unit.
interface modadd_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ-1:0][255:0] req_a;
    logic [N_REQ-1:0][255:0] req_b;
    logic [N_REQ-1:0]        done;
    logic [255:0]            result;
    logic                    busy;
    logic [IDX_W-1:0]        grant_idx;
    logic [255:0]            add_a;
    logic [255:0]            add_b;
    logic                    add_op;
    logic [255:0]            add_sum;

    modport slave (
        input  req, req_op, req_a, req_b, add_sum,
        output done, result, busy, grant_idx, add_a, add_b, add_op
    );

    modport master (
        output req, req_op, req_a, req_b, add_sum,
        input  done, result, busy, grant_idx, add_a, add_b, add_op
    );

endinterface

// File: rtl/modadd_arbiter.sv
// Round-robin arbiter that time-shares one external 256-bit modular add/sub unit
// among N_REQ requesters: grant, one execute cycle, one done cycle.
module modadd_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input logic              Clk,
    input logic              Reset_n,
    modadd_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    int unsigned      j;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!gnt_found && bus.req[j[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            bus.done      <= '0;
            bus.result    <= '0;
            bus.busy      <= 1'b0;
            bus.grant_idx <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_op    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        bus.grant_idx <= gnt_idx;
                        bus.add_a     <= bus.req_a[gnt_idx];
                        bus.add_b     <= bus.req_b[gnt_idx];
                        bus.add_op    <= bus.req_op[gnt_idx];
                        bus.busy      <= 1'b1;
                        state_q       <= StExec;
                    end
                end
                StExec: begin
                    bus.result <= bus.add_sum;
                    bus.done   <= {{(N_REQ-1){1'b0}}, 1'b1} << bus.grant_idx;
                    state_q    <= StDone;
                end
                StDone: begin
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    if (bus.grant_idx == IDX_W'(N_REQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= bus.grant_idx + 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_modadd_arbiter.sv
// Scoreboard bench for modadd_arbiter with a behavioural model of the shared
// modular add/sub unit on the add_* side.
module tb_modadd_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam logic [255:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct packed {
        logic [N-1:0] done;
        logic [255:0] res;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    modadd_arbiter_if #(.N_REQ(N), .IDX_W(IW)) bus ();

    modadd_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [255:0] modop(input logic op, input logic [255:0] a,
                                           input logic [255:0] b);
        logic [256:0] s;
        if (!op) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
            return s[255:0];
        end
        if (a >= b) return a - b;
        return a - b + P;
    endfunction

    assign bus.add_sum = modop(bus.add_op, bus.add_a, bus.add_b);

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_seen = 0;
    int           last_done_cyc = 0;
    bit           have_last = 1'b0;
    bit           gap_check = 1'b0;
    logic [N-1:0] auto_drop = '1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (bus.done != '0) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 256'(bus.done), 256'd0);
            end else begin
                e = sb.pop_front();
                check("done", 256'(bus.done), 256'(e.done));
                check("result", bus.result, e.res);
            end
            if (gap_check && have_last) check("rr_gap", 256'(cyc - last_done_cyc), 256'd3);
            last_done_cyc = cyc;
            have_last     = 1'b1;
            bus.req       = bus.req & ~(bus.done & auto_drop);
        end
    endtask

    task automatic issue(input int i, input logic op, input logic [255:0] a,
                         input logic [255:0] b, input logic [255:0] exp);
        exp_t e;
        e.done       = '0;
        e.done[i]    = 1'b1;
        e.res        = exp;
        bus.req_op[i] = op;
        bus.req_a[i]  = a;
        bus.req_b[i]  = b;
        bus.req[i]    = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        int k;
        target = done_seen + n;
        k = 0;
        while (done_seen < target && k < budget) begin
            tick();
            k++;
        end
        check("done_count", 256'(done_seen), 256'(target));
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_done"}, 256'(bus.done), 256'd0);
        check({tag, "_result"}, bus.result, 256'd0);
        check({tag, "_busy"}, 256'(bus.busy), 256'd0);
        check({tag, "_grant"}, 256'(bus.grant_idx), 256'd0);
        check({tag, "_add_a"}, bus.add_a, 256'd0);
        check({tag, "_add_op"}, 256'(bus.add_op), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        logic [255:0] a;
        logic [255:0] b;
        bus.req    = '0;
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;

        Reset_n = 1'b0;
        tick();
        tick();
        check_idle_reset("por");
        check("por_add_b", bus.add_b, 256'd0);
        Reset_n = 1'b1;
        tick();

        // Single add on requester 1.
        issue(1, 1'b0, 256'd5, 256'd3, 256'd8);
        tick();
        check("add_busy_t1", 256'(bus.busy), 256'd1);
        check("add_grant", 256'(bus.grant_idx), 256'd1);
        check("add_a", bus.add_a, 256'd5);
        check("add_b", bus.add_b, 256'd3);
        check("add_op", 256'(bus.add_op), 256'd0);
        check("add_done_t1", 256'(bus.done), 256'd0);
        tick();
        check("add_busy_t2", 256'(bus.busy), 256'd1);
        check("add_done_seen", 256'(done_seen), 256'd1);
        tick();
        check("add_busy_t3", 256'(bus.busy), 256'd0);
        check("add_result_held", bus.result, 256'd8);

        // Subtract with wrap, then add with wrap.
        issue(0, 1'b1, 256'd3, 256'd5, P - 256'd2);
        wait_done(1, 10);
        tick();
        issue(0, 1'b0, P - 256'd1, P - 256'd1, P - 256'd2);
        wait_done(1, 10);
        tick();

        // Reset during EXEC abandons the operation.
        bus.req_op[2] = 1'b0;
        bus.req_a[2]  = 256'd7;
        bus.req_b[2]  = 256'd1;
        bus.req[2]    = 1'b1;
        tick();
        check("rst_exec_busy", 256'(bus.busy), 256'd1);
        Reset_n = 1'b0;
        bus.req = '0;
        tick();
        tick();
        Reset_n = 1'b1;
        check_idle_reset("rst_mid");
        saved = done_seen;
        repeat (5) tick();
        check("rst_no_done", 256'(done_seen), 256'(saved));

        // All four requesting: strict 0,1,2,3 order, 3 cycles apart.
        for (int i = 0; i < 4; i++) begin
            a = P - 256'(i + 1);
            b = 256'(i * 7 + 2);
            issue(i, i[0], a, b, modop(i[0], a, b));
        end
        gap_check = 1'b1;
        have_last = 1'b0;
        wait_done(4, 40);
        gap_check = 1'b0;
        tick();

        // Pointer at 0 with requesters 0 and 3.
        issue(0, 1'b0, 256'd11, 256'd22, 256'd33);
        issue(3, 1'b1, 256'd50, 256'd8, 256'd42);
        wait_done(2, 20);
        tick();

        // Operands changed and req dropped during EXEC do not matter.
        issue(2, 1'b0, 256'd7, 256'd1, 256'd8);
        tick();
        bus.req_a[2] = 256'd9;
        bus.req[2]   = 1'b0;
        wait_done(1, 10);
        tick();

        // Requester 0 holds req; requester 3 is favoured by the pointer next.
        auto_drop = 4'b1110;
        issue(0, 1'b0, 256'd20, 256'd22, 256'd42);
        wait_done(1, 10);
        issue(3, 1'b1, 256'd10, 256'd4, 256'd6);
        issue(0, 1'b0, 256'd20, 256'd22, 256'd42);
        wait_done(2, 20);
        bus.req[0] = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", 256'(sb.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modadd_arbiter.md
Name: modadd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 256-bit modular add/sub unit (`add`, modulus `params.p`) among N_REQ requesters.
- Requesters are point-add, point-double and scalar-mult control units.
- The block registers the granted requester's operands, drives the shared unit for one cycle, captures the registered result and returns it with a per-requester done pulse.
- It sits between the EC point-arithmetic FSMs and the single shared `add` instance. That instance lives outside this block and connects through the `add_*` ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(N_REQ), width of the grant index.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- req  input  N_REQ  per-requester request level; held high with operands stable until that requester's done.
- req_op  input  N_REQ  per-requester operation: 0 = a+b mod p, 1 = a-b mod p.
- req_a  input  N_REQ x 256  per-requester operand a (packed array [N_REQ-1:0][255:0]).
- req_b  input  N_REQ x 256  per-requester operand b.
- done  output  N_REQ  one-hot, one-cycle completion pulse to the served requester.
- result  output  256  result of the last completed operation; valid when any done bit is high, held otherwise.
- busy  output  1  high while in EXEC or DONE.
- grant_idx  output  IDX_W  index of the requester being served or last served.
- add_a  output  256  operand a to the shared add unit.
- add_b  output  256  operand b to the shared add unit.
- add_op  output  1  op to the shared add unit.
- add_sum  input  256  combinational sum/difference from the shared add unit.

Behaviour:
- Reset (Reset_n = 0 at a clock edge, any state, including mid-operation):
  - state = IDLE; done = 0; result = 0; busy = 0; grant_idx = 0.
  - add_a, add_b and add_op registers = 0.
  - round-robin pointer = 0.
  - Any in-flight operation is abandoned and no done is issued.
- FSM states IDLE, EXEC, DONE:
  - IDLE, no req bit set: stay in IDLE.
  - IDLE, any req bit set: grant the first set bit searching upward from the pointer, wrapping at N_REQ-1 -> 0. In the same edge:
    - latch grant_idx;
    - latch add_a = req_a[g], add_b = req_b[g], add_op = req_op[g];
    - go to EXEC.
  - EXEC (1 cycle): add_* are stable from registers and the shared unit evaluates. At the edge: result <= add_sum; go to DONE.
  - DONE (1 cycle): done[grant_idx] = 1, all other done bits 0. At the edge: pointer <= (grant_idx+1) mod N_REQ; go to IDLE.
- Latency and throughput:
  - req sampled high in IDLE at edge T -> done high during cycle T+2, with result valid in that cycle.
  - One operation every 3 cycles maximum.
- busy: 1 in EXEC and DONE, 0 in IDLE.
- Handshake rules:
  - A requester must drop req in the cycle after its done. If req is still high at the IDLE edge, it is treated as a new request subject to round-robin order.
  - Operands are captured only at grant. Changes to req_a, req_b or req_op after the grant do not affect the operation.
  - Deassertion of req during EXEC or DONE is ignored; the operation completes and done still pulses.
- Fairness:
  - With all requesters continuously requesting, grants cycle 0,1,2,...,N_REQ-1,0,...
  - No requester waits more than N_REQ-1 operations.
  - Simultaneous requests are resolved solely by the pointer.
- Arithmetic: the block performs no arithmetic. result is add_sum exactly as registered at the end of EXEC, 256 bits, no truncation.
- add_a, add_b and add_op hold their last values in IDLE and DONE. They change only at a grant.

Test Plan:
- Reset: assert Reset_n = 0 for 2 cycles during EXEC of an op -> next cycle state IDLE, done = 0, result = 0, busy = 0, grant_idx = 0; no done pulse follows.
- Single add: req[1] = 1, op = 0, a = 5, b = 3 -> add_a = 5, add_b = 3, add_op = 0 in cycle T+1; done = 4'b0010 and result = 8 in cycle T+2; busy high in T+1 and T+2 only.
- Subtract wrap: req[0], op = 1, a = 3, b = 5 -> result = p-2. Also a = p-1, b = p-1, op = 0 -> result = p-2.
- Round-robin: req = 4'b1111 held, each requester drops req the cycle after its done -> done order 0,1,2,3, each pulse spaced 3 cycles apart. Then req = 4'b1001 with pointer = 0 -> grants 0 then 3.
- Operand isolation: change req_a[2] from 7 to 9 and drop req[2] during EXEC of a = 7, b = 1, op = 0 -> result = 8, done[2] still pulses.
- Held req: requester keeps req high after done while req[3] is also set -> the pointer-favoured requester is served next; the held requester is not served twice in a row.
